// File: rtl/door_access_pkg.sv
// rtl/door_access_pkg.sv - shared states and constants for the door access arbiter
package door_access_pkg;

   localparam int CODE_W      = 4;
   localparam int CODE_LO_DEF = 4;
   localparam int CODE_HI_DEF = 11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CHECK   = 3'd1,
      ST_GRANTED = 3'd2,
      ST_DENIED  = 3'd3,
      ST_LOCKOUT = 3'd4
   } state_t;

endpackage

// File: rtl/door_access_arbiter_if.sv
// rtl/door_access_arbiter_if.sv - keypad/door bundle between front-ends and the arbiter
interface door_access_arbiter_if #(
   parameter int N_PADS = 4
);
   import door_access_pkg::*;

   logic [N_PADS-1:0]        validate_code;
   logic [CODE_W*N_PADS-1:0] access_code;
   logic [N_PADS-1:0]        grant;
   logic                     open_access_door;
   logic                     alarm;
   logic [3:0]               fail_cnt;
   logic [2:0]               state_out;

   modport master (
      output validate_code, access_code,
      input  grant, open_access_door, alarm, fail_cnt, state_out
   );

   modport slave (
      input  validate_code, access_code,
      output grant, open_access_door, alarm, fail_cnt, state_out
   );

endinterface

// File: rtl/door_access_arbiter_rr_arbiter.sv
// rtl/door_access_arbiter_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic             any_req,
   output logic [PTR_W-1:0] winner,
   output logic [N-1:0]     onehot
);

   int idx;

   // Walk offsets from the far end down so the nearest set bit to ptr wins last.
   always_comb begin
      winner = '0;
      idx    = 0;
      for (int i = N - 1; i >= 0; i--) begin
         idx = (int'(ptr) + i) % N;
         if (req[idx]) winner = PTR_W'(idx);
      end
      any_req = |req;
      onehot  = '0;
      if (any_req) onehot[winner] = 1'b1;
   end

endmodule

// File: rtl/door_access_arbiter.sv
// rtl/door_access_arbiter.sv - shares one code checker and door actuator among keypads
module door_access_arbiter
   import door_access_pkg::*;
#(
   parameter int N_PADS         = 4,
   parameter int CODE_LO        = CODE_LO_DEF,
   parameter int CODE_HI        = CODE_HI_DEF,
   parameter int OPEN_CYCLES    = 16,
   parameter int MAX_FAILS      = 3,
   parameter int LOCKOUT_CYCLES = 32
) (
   input logic                  clk,
   input logic                  rst,
   door_access_arbiter_if.slave bus
);

   localparam int PTR_W = $clog2(N_PADS);

   state_t              state_q, state_d;
   logic [PTR_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [N_PADS-1:0]   grant_q, grant_d;
   logic [CODE_W-1:0]   code_q, code_d;
   logic [3:0]          fail_q, fail_d, fail_inc;
   logic [7:0]          timer_q, timer_d;
   logic                any_req;
   logic [PTR_W-1:0]    arb_win;
   logic [N_PADS-1:0]   arb_onehot;

   rr_arbiter #(.N(N_PADS), .PTR_W(PTR_W)) u_rr (
      .req     (bus.validate_code),
      .ptr     (rr_ptr_q),
      .any_req (any_req),
      .winner  (arb_win),
      .onehot  (arb_onehot)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         code_q   <= '0;
         fail_q   <= '0;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         code_q   <= code_d;
         fail_q   <= fail_d;
         timer_q  <= timer_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = grant_q;
      code_d   = code_q;
      fail_d   = fail_q;
      timer_d  = timer_q;
      fail_inc = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;
      case (state_q)
         ST_IDLE: begin
            // The winner is kept as a one-hot mask since it only drives grant later.
            if (any_req) begin
               grant_d  = arb_onehot;
               code_d   = bus.access_code[int'(arb_win)*CODE_W +: CODE_W];
               rr_ptr_d = (arb_win == PTR_W'(N_PADS - 1)) ? '0 : arb_win + 1'b1;
               state_d  = ST_CHECK;
            end
         end
         ST_CHECK: begin
            timer_d = '0;
            if (code_q >= CODE_W'(CODE_LO) && code_q <= CODE_W'(CODE_HI)) begin
               fail_d  = '0;
               state_d = ST_GRANTED;
            end else if (fail_inc == 4'(MAX_FAILS)) begin
               fail_d  = 4'(MAX_FAILS);
               state_d = ST_LOCKOUT;
            end else begin
               fail_d  = fail_inc;
               state_d = ST_DENIED;
            end
         end
         ST_GRANTED: begin
            timer_d = timer_q + 8'd1;
            if (timer_q == 8'(OPEN_CYCLES - 1)) state_d = ST_IDLE;
         end
         ST_DENIED: state_d = ST_IDLE;
         ST_LOCKOUT: begin
            timer_d = timer_q + 8'd1;
            if (timer_q == 8'(LOCKOUT_CYCLES - 1)) begin
               fail_d  = '0;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign bus.grant            = (state_q == ST_CHECK) ? grant_q : '0;
   assign bus.open_access_door = (state_q == ST_GRANTED);
   assign bus.alarm            = (state_q == ST_LOCKOUT);
   assign bus.fail_cnt         = fail_q;
   assign bus.state_out        = state_q;

endmodule

// File: tb/tb_door_access_arbiter.sv
// tb/tb_door_access_arbiter.sv - scoreboard bench for door_access_arbiter
module tb_door_access_arbiter;

   localparam int N = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   door_access_arbiter_if #(.N_PADS(N)) bus ();

   door_access_arbiter #(
      .N_PADS(N), .CODE_LO(4), .CODE_HI(11),
      .OPEN_CYCLES(16), .MAX_FAILS(3), .LOCKOUT_CYCLES(32)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      int pad;
      int outcome;
      int fcnt;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   errors = 0;
   bit   mon_en = 1'b0;
   bit   mon_busy = 1'b0;
   int   m_ptr = 0;
   int   m_fails = 0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: outcome of one code check given the running failure count.
   function automatic void predict(input int pad, input int code);
      exp_t e;
      e.pad = pad;
      if (code >= 4 && code <= 11) begin
         m_fails = 0; e.outcome = 2; e.fcnt = 0;
      end else if (m_fails + 1 == 3) begin
         m_fails = 0; e.outcome = 4; e.fcnt = 3;
      end else begin
         m_fails++; e.outcome = 3; e.fcnt = m_fails;
      end
      sb.push_back(e);
   endfunction

   task automatic run_batch(input logic [3:0] mask, input logic [15:0] codes, input int late);
      int  pend;
      int  w;
      int  c;
      bit  late_done;
      bit  done;
      pend = int'(mask);
      late_done = (late < 0);
      while (pend != 0) begin
         w = -1;
         for (int k = 0; k < N; k++)
            if (w < 0 && pend[(m_ptr + k) % N]) w = (m_ptr + k) % N;
         c = int'((codes >> (4 * w)) & 16'hF);
         predict(w, c);
         pend = pend & ~(1 << w);
         m_ptr = (w + 1) % N;
         if (!late_done) begin
            pend = pend | (1 << late);
            late_done = 1'b1;
         end
      end
      @(negedge clk);
      bus.access_code   = codes;
      bus.validate_code = mask;
      late_done = (late < 0);
      done = 1'b0;
      for (int cyc = 0; cyc < 3000 && !done; cyc++) begin
         @(negedge clk);
         if (bus.grant != 0) begin
            bus.validate_code = bus.validate_code & ~bus.grant;
            if (!late_done) begin
               bus.validate_code[late] = 1'b1;
               late_done = 1'b1;
            end
         end
         if (bus.validate_code == 0 && late_done && sb.size() == 0 && !mon_busy && bus.state_out == 3'd0)
            done = 1'b1;
      end
      chk("batch_complete", int'(done), 1);
   endtask

   exp_t       me;
   int         mn;
   int         mstray;
   logic [3:0] meg;

   initial begin
      forever begin
         @(negedge clk);
         if (mon_en && bus.grant != 0) begin
            if (sb.size() == 0) begin
               chk("unexpected_grant", int'(bus.grant), 0);
            end else begin
               me = sb.pop_front();
               mon_busy = 1'b1;
               meg = 4'b0001 << me.pad;
               chk("grant", int'(bus.grant), int'(meg));
               @(negedge clk);
               chk("state_after_check", int'(bus.state_out), me.outcome);
               chk("fail_cnt", int'(bus.fail_cnt), me.fcnt);
               mn = 0;
               mstray = 0;
               if (me.outcome == 2) begin
                  while (bus.open_access_door && mn < 300) begin
                     mn++;
                     if (bus.grant != 0 || bus.alarm) mstray++;
                     @(negedge clk);
                  end
                  chk("door_cycles", mn, 16);
                  chk("idle_after_open", int'(bus.state_out), 0);
               end else if (me.outcome == 4) begin
                  while (bus.alarm && mn < 300) begin
                     mn++;
                     if (bus.grant != 0 || bus.open_access_door || bus.fail_cnt != 4'd3) mstray++;
                     @(negedge clk);
                  end
                  chk("alarm_cycles", mn, 32);
                  chk("fail_cnt_after_lockout", int'(bus.fail_cnt), 0);
                  chk("idle_after_lockout", int'(bus.state_out), 0);
               end else begin
                  if (bus.grant != 0 || bus.open_access_door || bus.alarm) mstray++;
               end
               chk("stray_outputs", mstray, 0);
               mon_busy = 1'b0;
            end
         end
      end
   end

   initial begin
      int         late;
      int         k;
      logic [3:0] mask;
      bus.validate_code = '0;
      bus.access_code   = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_state", int'(bus.state_out), 0);
      chk("rst_grant", int'(bus.grant), 0);
      chk("rst_door", int'(bus.open_access_door), 0);
      chk("rst_alarm", int'(bus.alarm), 0);
      chk("rst_fail_cnt", int'(bus.fail_cnt), 0);
      rst = 1'b0;

      // Reset landing in the fifth open cycle must end the opening at once.
      bus.access_code   = 16'h0009;
      bus.validate_code = 4'b0001;
      for (int c = 0; c < 50 && bus.grant == 0; c++) @(negedge clk);
      chk("rst_test_grant", int'(bus.grant), 1);
      bus.validate_code = '0;
      for (int c = 0; c < 50 && !bus.open_access_door; c++) @(negedge clk);
      repeat (4) @(negedge clk);
      chk("door_5th_cycle", int'(bus.open_access_door), 1);
      rst = 1'b1;
      @(negedge clk);
      chk("midrst_door", int'(bus.open_access_door), 0);
      chk("midrst_state", int'(bus.state_out), 0);
      chk("midrst_fail_cnt", int'(bus.fail_cnt), 0);
      rst = 1'b0;
      m_ptr = 0;
      m_fails = 0;
      mon_en = 1'b1;

      run_batch(4'b1111, 16'h8765, -1);
      run_batch(4'b0001, 16'h0005, -1);
      run_batch(4'b0010, 16'h0090, -1);
      run_batch(4'b0001, 16'h0003, -1);
      run_batch(4'b0001, 16'h0004, -1);
      run_batch(4'b0001, 16'h000B, -1);
      run_batch(4'b0001, 16'h000C, -1);
      run_batch(4'b0001, 16'h0005, -1);
      run_batch(4'b0100, 16'h0000, -1);
      run_batch(4'b0100, 16'h0000, -1);
      run_batch(4'b0100, 16'h0005, 0);
      run_batch(4'b1000, 16'h0000, -1);
      run_batch(4'b1000, 16'h0000, -1);
      run_batch(4'b1000, 16'h7000, -1);

      for (int t = 0; t < 40; t++) begin
         mask = 4'($urandom_range(1, 15));
         late = -1;
         if ($urandom_range(0, 2) == 0) begin
            k = int'($urandom_range(0, N - 1));
            if (!mask[k]) late = k;
         end
         run_batch(mask, 16'($urandom), late);
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule
